// File: rtl/mpc_mul_arbiter.sv
// mpc_mul_arbiter: round-robin front end for one shared pipelined signed x unsigned multiplier.
// Registers the granted operands into the multiplier, tracks each product with a
// {valid, id} tag pipeline and freezes everything through mul_ce under backpressure.
module mpc_mul_arbiter #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned A_W     = 21,
   parameter int unsigned B_W     = 12,
   parameter int unsigned P_W     = 34,
   parameter int unsigned MUL_LAT = 3,
   localparam int unsigned ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [N_REQ-1:0]       i_req_valid,
   input  logic [N_REQ*A_W-1:0]   i_req_a,
   input  logic [N_REQ*B_W-1:0]   i_req_b,
   output logic [N_REQ-1:0]       o_req_ready,
   output logic                   o_mul_ce,
   output logic [A_W-1:0]         o_mul_a,
   output logic [B_W-1:0]         o_mul_b,
   input  logic [P_W-1:0]         i_mul_p,
   output logic                   o_rsp_valid,
   output logic [ID_W-1:0]        o_rsp_id,
   output logic [P_W-1:0]         o_rsp_p,
   input  logic                   i_rsp_ready,
   output logic                   o_busy
);

   logic                w_ce;
   logic                w_found;
   logic [ID_W-1:0]     w_idx;
   logic                w_grant;
   logic [N_REQ-1:0]    w_onehot;
   logic [A_W-1:0]      w_sel_a;
   logic [B_W-1:0]      w_sel_b;

   logic [ID_W-1:0]     r_last;
   logic [A_W-1:0]      r_mul_a;
   logic [B_W-1:0]      r_mul_b;
   logic [MUL_LAT:0]    r_tag_vld;
   logic [ID_W-1:0]     r_tag_id [MUL_LAT+1];

   // A held, unaccepted result stalls the whole pipeline including the multiplier.
   assign w_ce = !(r_tag_vld[MUL_LAT] && !i_rsp_ready);

   // Round-robin search starting just after the last granted requester.
   always_comb begin
      logic [ID_W:0] v_pos;
      w_found = 1'b0;
      w_idx   = '0;
      v_pos   = '0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         v_pos = (ID_W+1)'(r_last) + (ID_W+1)'(k);
         if (v_pos >= (ID_W+1)'(N_REQ)) begin
            v_pos = v_pos - (ID_W+1)'(N_REQ);
         end
         if (!w_found && i_req_valid[v_pos[ID_W-1:0]]) begin
            w_found = 1'b1;
            w_idx   = v_pos[ID_W-1:0];
         end
      end
   end

   // Reset wins over a grant; a stall also suppresses it.
   assign w_grant = w_found && w_ce && !i_rst;

   // One-hot accept and operand mux for the granted requester.
   always_comb begin
      w_onehot = '0;
      w_sel_a  = '0;
      w_sel_b  = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (w_idx == ID_W'(i)) begin
            w_onehot[i] = w_grant;
            w_sel_a     = i_req_a[i*A_W +: A_W];
            w_sel_b     = i_req_b[i*B_W +: B_W];
         end
      end
   end

   // Operand register, tag pipeline and round-robin pointer; all hold while stalled.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_last    <= ID_W'(N_REQ - 1);
         r_mul_a   <= '0;
         r_mul_b   <= '0;
         r_tag_vld <= '0;
         for (int unsigned i = 0; i <= MUL_LAT; i++) begin
            r_tag_id[i] <= '0;
         end
      end else if (w_ce) begin
         // Bubbles load zero operands so the multiplier sees quiet inputs.
         r_mul_a     <= w_grant ? w_sel_a : '0;
         r_mul_b     <= w_grant ? w_sel_b : '0;
         r_tag_vld   <= {r_tag_vld[MUL_LAT-1:0], w_grant};
         r_tag_id[0] <= w_idx;
         for (int unsigned i = 1; i <= MUL_LAT; i++) begin
            r_tag_id[i] <= r_tag_id[i-1];
         end
         if (w_grant) begin
            r_last <= w_idx;
         end
      end
   end

   assign o_req_ready = w_onehot;
   assign o_mul_ce    = w_ce;
   assign o_mul_a     = r_mul_a;
   assign o_mul_b     = r_mul_b;
   assign o_rsp_valid = r_tag_vld[MUL_LAT];
   assign o_rsp_id    = r_tag_id[MUL_LAT];
   assign o_rsp_p     = i_mul_p;
   assign o_busy      = |r_tag_vld;

endmodule

// File: tb/tb_mpc_mul_arbiter.sv
// Self-checking bench for mpc_mul_arbiter with a behavioural multiplier and a
// queue-based reference model checked on every cycle.
module tb_mpc_mul_arbiter;

   localparam int N   = 4;
   localparam int AW  = 21;
   localparam int BW  = 12;
   localparam int PW  = 34;
   localparam int LAT = 3;
   localparam int IW  = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N*AW-1:0] req_a;
   logic [N*BW-1:0] req_b;
   logic [N-1:0]    req_ready;
   logic            mul_ce;
   logic [AW-1:0]   mul_a;
   logic [BW-1:0]   mul_b;
   logic [PW-1:0]   mul_p;
   logic            rsp_valid;
   logic [IW-1:0]   rsp_id;
   logic [PW-1:0]   rsp_p;
   logic            rsp_ready;
   logic            busy;

   logic [AW-1:0]   ta   [N];
   logic [BW-1:0]   tb_v [N];

   always #5 clk = ~clk;

   mpc_mul_arbiter #(
      .N_REQ   (N),
      .A_W     (AW),
      .B_W     (BW),
      .P_W     (PW),
      .MUL_LAT (LAT)
   ) u_dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req_valid (req_valid),
      .i_req_a     (req_a),
      .i_req_b     (req_b),
      .o_req_ready (req_ready),
      .o_mul_ce    (mul_ce),
      .o_mul_a     (mul_a),
      .o_mul_b     (mul_b),
      .i_mul_p     (mul_p),
      .o_rsp_valid (rsp_valid),
      .o_rsp_id    (rsp_id),
      .o_rsp_p     (rsp_p),
      .i_rsp_ready (rsp_ready),
      .o_busy      (busy)
   );

   always_comb begin
      for (int i = 0; i < N; i++) begin
         req_a[i*AW +: AW] = ta[i];
         req_b[i*BW +: BW] = tb_v[i];
      end
   end

   function automatic longint prod(logic [AW-1:0] a, logic [BW-1:0] b);
      return longint'($signed(a)) * longint'({1'b0, b});
   endfunction

   // Behavioural multiplier: three clock-enabled stages, no reset.
   logic [PW-1:0] m1 = '0, m2 = '0, m3 = '0;
   always @(posedge clk) begin
      if (mul_ce) begin
         m1 <= PW'(prod(mul_a, mul_b));
         m2 <= m1;
         m3 <= m2;
      end
   end
   assign mul_p = m3;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(string name, longint act, longint exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: issued products queue in grant order, each tagged with the
   // count of unstalled edges at issue; a product is due LAT unstalled edges later.
   typedef struct {
      int     id;
      longint p;
      longint m;
   } item_t;

   item_t  q[$];
   longint cnt   = 0;
   int     last  = N - 1;
   bit     armed = 1'b0;
   bit     e_valid, e_ce, e_gany;
   int     e_gidx;
   longint e_gp;

   // Predict and compare all outputs mid-cycle.
   always @(negedge clk) begin
      int idx;
      e_valid = (q.size() > 0) && (cnt - q[0].m == LAT);
      e_ce    = !(e_valid && !rsp_ready);
      e_gany  = 1'b0;
      e_gidx  = 0;
      if (!rst && e_ce) begin
         for (int k = 1; k <= N; k++) begin
            idx = (last + k) % N;
            if (!e_gany && req_valid[idx]) begin
               e_gany = 1'b1;
               e_gidx = idx;
            end
         end
      end
      e_gp = prod(ta[e_gidx], tb_v[e_gidx]);
      if (armed) begin
         check("req_ready", longint'(req_ready), e_gany ? (longint'(1) << e_gidx) : 0);
         check("mul_ce", longint'(mul_ce), longint'(e_ce));
         check("rsp_valid", longint'(rsp_valid), longint'(e_valid));
         check("busy", longint'(busy), longint'(q.size() > 0));
         if (e_valid) begin
            check("rsp_id", longint'(rsp_id), longint'(q[0].id));
            check("rsp_p", longint'($signed(rsp_p)), q[0].p);
         end
      end
   end

   // Advance the model at each clock edge.
   always @(posedge clk) begin
      if (rst) begin
         armed = 1'b1;
         q.delete();
         last = N - 1;
      end else if (e_ce) begin
         cnt++;
         if (e_valid) begin
            void'(q.pop_front());
         end
         if (e_gany) begin
            q.push_back('{id: e_gidx, p: e_gp, m: cnt});
            last = e_gidx;
         end
      end
   end

   // Requester/consumer driver.
   int           prob_req = 0;
   int           prob_rdy = 100;
   logic [N-1:0] acc_g;

   task automatic samp();
      @(negedge clk);
      #1;
      acc_g = req_ready;
   endtask

   task automatic drv();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (acc_g[i]) begin
            req_valid[i] = 1'b0;
         end
         if (!req_valid[i] && ($urandom_range(99) < prob_req)) begin
            req_valid[i] = 1'b1;
            ta[i]        = AW'($urandom);
            tb_v[i]      = BW'($urandom);
         end
      end
      rsp_ready = ($urandom_range(99) < prob_rdy);
   endtask

   task automatic step();
      samp();
      drv();
   endtask

   task automatic drain();
      prob_req = 0;
      prob_rdy = 100;
      repeat (16) step();
      check("drain_busy", longint'(busy), 0);
   endtask

   task automatic issue_one(string name, int id, int a, int b, longint expp);
      req_valid[id] = 1'b1;
      ta[id]        = AW'(a);
      tb_v[id]      = BW'(b);
      samp();
      check({name, "_grant"}, longint'(acc_g), longint'(1) << id);
      drv();
      repeat (3) step();
      samp();
      check({name, "_valid"}, longint'(rsp_valid), 1);
      check({name, "_id"}, longint'(rsp_id), longint'(id));
      check({name, "_p"}, longint'($signed(rsp_p)), expp);
      drv();
      samp();
      check({name, "_idle"}, longint'(busy), 0);
      drv();
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b1;
      for (int i = 0; i < N; i++) begin
         ta[i]   = '0;
         tb_v[i] = '0;
      end

      // Reset values, with a request present during reset.
      @(posedge clk);
      #1;
      req_valid = 4'b0010;
      ta[1]     = AW'(5);
      tb_v[1]   = BW'(5);
      samp();
      check("rst_req_ready", longint'(req_ready), 0);
      check("rst_mul_ce", longint'(mul_ce), 1);
      check("rst_mul_a", longint'(mul_a), 0);
      check("rst_mul_b", longint'(mul_b), 0);
      check("rst_rsp_valid", longint'(rsp_valid), 0);
      check("rst_rsp_id", longint'(rsp_id), 0);
      check("rst_busy", longint'(busy), 0);
      drv();
      rst       = 1'b0;
      req_valid = '0;

      // Single issue and arithmetic extremes.
      issue_one("single", 2, 1000, 7, 64'sd7000);
      issue_one("neg_ext", 0, -1048576, 4095, -64'sd4293918720);
      issue_one("pos_ext", 1, 1048575, 4095, 64'sd4293914625);
      issue_one("b_unsigned", 3, -3, 2048, -64'sd6144);

      // Fairness: all requesters continuously valid from a fresh reset.
      rst = 1'b1;
      step();
      rst      = 1'b0;
      prob_req = 100;
      for (int i = 0; i < N; i++) begin
         req_valid[i] = 1'b1;
         ta[i]        = AW'($urandom);
         tb_v[i]      = BW'($urandom);
      end
      for (int k = 0; k < 12; k++) begin
         samp();
         check("fair_grant", longint'(acc_g), longint'(1) << (k % N));
         drv();
      end

      // Backpressure for three cycles with the pipeline full.
      prob_rdy = 0;
      step();
      for (int k = 0; k < 3; k++) begin
         samp();
         check("bp_mul_ce", longint'(mul_ce), 0);
         check("bp_req_ready", longint'(req_ready), 0);
         check("bp_rsp_valid", longint'(rsp_valid), 1);
         check("bp_rsp_p", longint'($signed(rsp_p)), q[0].p);
         drv();
      end
      prob_rdy = 100;
      drain();

      // Random traffic with random backpressure.
      prob_req = 40;
      prob_rdy = 70;
      repeat (400) step();
      drain();

      // Bubbles: requester 0 issues every other cycle.
      for (int k = 0; k < 12; k++) begin
         if (k % 2 == 0) begin
            req_valid[0] = 1'b1;
            ta[0]        = AW'($urandom);
            tb_v[0]      = BW'($urandom);
         end
         samp();
         check("bubble_grant", longint'(acc_g), (k % 2 == 0) ? 1 : 0);
         if (k >= 4) begin
            check("bubble_rsp", longint'(rsp_valid), (k % 2 == 0) ? 1 : 0);
         end
         drv();
      end
      drain();

      // Reset with three products in flight.
      prob_req = 100;
      for (int i = 0; i < N; i++) begin
         req_valid[i] = 1'b1;
         ta[i]        = AW'($urandom);
         tb_v[i]      = BW'($urandom);
      end
      repeat (3) step();
      rst = 1'b1;
      samp();
      check("midrst_no_grant", longint'(req_ready), 0);
      drv();
      rst      = 1'b0;
      prob_req = 0;
      samp();
      check("midrst_rsp_valid", longint'(rsp_valid), 0);
      check("midrst_busy", longint'(busy), 0);
      check("midrst_first_grant", longint'(req_ready), 1);
      drv();
      repeat (6) step();
      drain();

      // Final random burst.
      prob_req = 70;
      prob_rdy = 50;
      repeat (200) step();
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mpc_mul_arbiter.md
# mpc_mul_arbiter

Round-robin scheduler that shares one pipelined signed×unsigned multiplier (21-bit signed × 12-bit unsigned → 34-bit signed, 3 clock-enabled register stages, no reset) among several MPC datapath requesters. It sits between the requesters and the multiplier instance, and registers the operands into the multiplier. It tracks each in-flight product with a tag pipeline and returns results in issue order with the requester ID. Downstream backpressure freezes the whole pipeline through the multiplier's `ce`.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `A_W`, default 21: signed operand width.
- `B_W`, default 12: unsigned operand width.
- `P_W`, default 34: product width.
- `MUL_LAT`, default 3: number of `ce`-qualified edges from the multiplier sampling `a`/`b` to `p` being valid.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in N_REQ: per-requester operand valid.
- `req_a` in N_REQ*A_W: packed signed operands, requester i at [i*A_W +: A_W].
- `req_b` in N_REQ*B_W: packed unsigned operands.
- `req_ready` out N_REQ: one-hot grant and accept for the current cycle.
- `mul_ce` out 1: multiplier clock enable.
- `mul_a` out A_W: registered operand to the multiplier.
- `mul_b` out B_W: registered operand to the multiplier.
- `mul_p` in P_W: multiplier product.
- `rsp_valid` out 1: result valid.
- `rsp_id` out clog2(N_REQ): requester that issued the result.
- `rsp_p` out P_W: product, equal to `mul_p`.
- `rsp_ready` in 1: downstream accepts the result.
- `busy` out 1: any tag valid.

## Operation
- Stall: `mul_ce = !(rsp_valid && !rsp_ready)`. When `mul_ce` = 0, every register in this block and in the multiplier holds its value.
- Arbitration: round-robin pointer `last` (the last granted index). When `mul_ce` = 1, grant the first i with `req_valid[i]` = 1, searching from `last+1` modulo N_REQ. `req_ready[i] = mul_ce && grant[i]`. On a grant, `last <= i`.
- Requester handshake: a transfer occurs when `req_valid && req_ready`. Requesters hold `req_valid`, `req_a` and `req_b` stable until accepted. A pending request waits at most N_REQ-1 other grants.
- Operand stage: on a `mul_ce` edge, `mul_a`/`mul_b` load the granted operands. With no grant they load 0 (bubble).
- Tag pipeline: MUL_LAT+1 stages of {valid, id}. Stage 0 loads {grant_any, grant_idx} and all stages shift on a `mul_ce` edge. `rsp_valid` is last-stage valid and `rsp_id` is last-stage id.
- Arithmetic: `rsp_p` = sign-extended `req_a` × zero-extended `req_b`. The result is exact in P_W bits, so there is no saturation.
- Reset: `last <= N_REQ-1`, so requester 0 has first priority. All tag valids clear. `mul_a`/`mul_b` are 0.
  - In-flight products are discarded and not replayed.
  - The multiplier's internal state is don't-care because the tags are invalid.
- Reset value of every output: `req_ready` 0 (reset takes priority over grant), `mul_ce` 1, `mul_a` 0, `mul_b` 0, `rsp_valid` 0, `rsp_id` 0, `busy` 0. `rsp_p` follows `mul_p` and is undefined until the first valid result.

## Timing
- Latency: grant at edge k, `rsp_valid` asserted after edge k+MUL_LAT+1, which is 4 cycles at defaults with no stall. Each stalled cycle adds exactly one cycle.
- Throughput: one grant and one response per unstalled cycle.
- Combinational paths:
  - `rsp_ready` → `mul_ce` → `req_ready`.
  - `req_valid` → `req_ready`.
  - There is no path from `req_*` to `rsp_*`.
- Simultaneous events:
  - A response accepted in the same cycle as a grant: both proceed.
  - `rsp_valid && !rsp_ready` with requests pending: no grant, and `rsp_*` is held bit-stable.
  - `rst` together with `req_valid`: no grant.
- `busy` is the OR of all tag valids.

## Test plan
- Single issue: requester 2 sends a=1000, b=7, all other requesters idle → `req_ready` = 4'b0100 for one cycle; 4 cycles later `rsp_valid` = 1, `rsp_id` = 2, `rsp_p` = 7000, followed by `busy` = 0.
- Sign and width extremes:
  - a = -1048576, b = 4095 → `rsp_p` = -4293918720.
  - a = 1048575, b = 4095 → `rsp_p` = 4293914625.
  - b ≥ 2048 is never treated as negative.
- Fairness: all 4 requesters valid continuously for 12 cycles → grant order 0,1,2,3,0,1,… and `rsp_id` follows the same order, one response per cycle after a 4-cycle fill.
- Backpressure: `rsp_ready` held low for 3 cycles while a result is valid → `mul_ce` = 0, `req_ready` = 0, and `rsp_*` is stable. On release, all products arrive in order with none lost or duplicated, compared against a scoreboard.
- Bubbles: requests issued in alternate cycles → `rsp_valid` toggles in the same alternating pattern, and bubble slots never assert `rsp_valid`.
- Reset mid-flight: `rst` asserted for 1 cycle with 3 products in flight → the next cycle has `rsp_valid` = 0 and `busy` = 0. No stale response appears during the next 6 cycles, and the first grant after reset goes to requester 0.
